// File: rtl/scan_decoder_pkg.sv
// Shared definitions for the scan decoder: mode encodings and the one-hot
// pattern helper used for the display select lines.
package scan_pkg;

    // Mode input encodings
    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Widest pattern the helper builds; callers cast down to their N_OUT
    localparam int ONEHOT_MAX_W = 256;

    // One-hot pattern for index sel; inverted when the outputs are active-low.
    // Bits above the caller's N_OUT are dropped by the caller's size cast.
    function automatic logic [ONEHOT_MAX_W-1:0] onehot(input logic [7:0] sel,
                                                       input logic       act_low);
        logic [ONEHOT_MAX_W-1:0] v;
        v      = {ONEHOT_MAX_W{1'b0}};
        v[sel] = 1'b1;
        if (act_low) begin
            v = ~v;
        end else begin
            v = v;
        end
        return v;
    endfunction

endpackage

// File: rtl/scan_decoder_tick_gen.sv
// Scan-rate prescaler. Counts 0..TICK_DIV-1 while running, freezes while
// held, and clears whenever scanning is not selected so that a later switch
// into scan mode always starts a full step period.
module tick_gen #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic hold,
    output logic tick
);

    localparam int PRE_W = $clog2(TICK_DIV) + 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

    logic [PRE_W-1:0] presc_r;
    logic             wrap_s;

    // Terminal count reached on an edge where the counter is allowed to move
    assign wrap_s = run && !hold && (presc_r == PRE_LAST);
    assign tick   = wrap_s;

    // Prescaler: hold has priority so a disabled display keeps its phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r <= {PRE_W{1'b0}};
        end else if (hold) begin
            presc_r <= presc_r;
        end else if (!run) begin
            presc_r <= {PRE_W{1'b0}};
        end else if (wrap_s) begin
            presc_r <= {PRE_W{1'b0}};
        end else begin
            presc_r <= presc_r + PRE_ONE;
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot select-line decoder for multiplexed displays. Manual
// mode decodes sel_in directly; scan mode walks idx through the first
// N_ACTIVE outputs at the prescaled rate, with optional blanking after
// each step to suppress ghosting.
module scan_decoder
    import scan_pkg::*;
#(
    parameter int SEL_W    = 3,
    parameter int N_ACTIVE = 8,
    parameter int TICK_DIV = 100000,
    parameter int BLANK    = 2,
    parameter int ACT_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel_in,
    output logic [(2**SEL_W)-1:0] y,
    output logic [SEL_W-1:0]      idx,
    output logic                  tick
);

    localparam int N_OUT = 2 ** SEL_W;
    localparam int BLK_W = (BLANK > 0) ? $clog2(BLANK + 1) : 1;

    localparam logic [N_OUT-1:0] INACT    = (ACT_LOW != 0) ? {N_OUT{1'b1}} : {N_OUT{1'b0}};
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(N_ACTIVE - 1);
    localparam logic [SEL_W-1:0] IDX_ONE  = SEL_W'(1);
    localparam logic [BLK_W-1:0] BLK_INIT = BLK_W'(BLANK);
    localparam logic [BLK_W-1:0] BLK_ONE  = BLK_W'(1);
    localparam logic             POL_LOW  = (ACT_LOW != 0);

    // Reject parameter sets that cannot produce a sensible scan
    if (N_ACTIVE < 1 || N_ACTIVE > N_OUT) begin : g_bad_n_active
        $error("scan_decoder: N_ACTIVE must be within 1..2**SEL_W");
    end
    if (TICK_DIV < 1) begin : g_bad_tick_div
        $error("scan_decoder: TICK_DIV must be at least 1");
    end
    if (SEL_W < 1 || SEL_W > 8) begin : g_bad_sel_w
        $error("scan_decoder: SEL_W must be within 1..8");
    end

    logic [SEL_W-1:0] idx_r,   idx_nxt_s;
    logic [BLK_W-1:0] blank_r, blank_nxt_s;
    logic [N_OUT-1:0] y_r,     y_nxt_s;
    logic             tick_r,  tick_nxt_s;
    logic             wrap_s;
    logic             run_s;
    logic             hold_s;

    assign run_s  = (mode == MODE_SCAN);
    assign hold_s = !en;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run_s),
        .hold  (hold_s),
        .tick  (wrap_s)
    );

    // Next-state for index, blanking and output pattern; en=0 blanks and freezes
    always_comb begin
        idx_nxt_s   = idx_r;
        blank_nxt_s = blank_r;
        y_nxt_s     = y_r;
        tick_nxt_s  = 1'b0;
        if (!en) begin
            y_nxt_s = INACT;
        end else if (mode == MODE_MANUAL) begin
            idx_nxt_s   = sel_in;
            blank_nxt_s = {BLK_W{1'b0}};
            y_nxt_s     = N_OUT'(onehot(8'(sel_in), POL_LOW));
        end else begin
            if (wrap_s) begin
                tick_nxt_s  = 1'b1;
                blank_nxt_s = BLK_INIT;
                if (idx_r >= IDX_LAST) begin
                    idx_nxt_s = {SEL_W{1'b0}};
                end else begin
                    idx_nxt_s = idx_r + IDX_ONE;
                end
            end else if (blank_r != {BLK_W{1'b0}}) begin
                blank_nxt_s = blank_r - BLK_ONE;
            end else begin
                blank_nxt_s = blank_r;
            end
            // Blank while the updated counter is non-zero: exactly BLANK dark cycles per step
            if (blank_nxt_s != {BLK_W{1'b0}}) begin
                y_nxt_s = INACT;
            end else begin
                y_nxt_s = N_OUT'(onehot(8'(idx_nxt_s), POL_LOW));
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r   <= {SEL_W{1'b0}};
            blank_r <= {BLK_W{1'b0}};
            y_r     <= INACT;
            tick_r  <= 1'b0;
        end else begin
            idx_r   <= idx_nxt_s;
            blank_r <= blank_nxt_s;
            y_r     <= y_nxt_s;
            tick_r  <= tick_nxt_s;
        end
    end

    assign y    = y_r;
    assign idx  = idx_r;
    assign tick = tick_r;

endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder: an active-high instance covers the
// functional scenarios; an active-low twin shares the same inputs.
module tb_scan_decoder;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       mode;
    logic [1:0] sel_in;
    logic [3:0] y;
    logic [1:0] idx;
    logic       tick;
    logic [3:0] y_l;
    logic [1:0] idx_l;
    logic       tick_l;

    int cmp_cnt = 0;
    int err_cnt = 0;

    scan_decoder #(
        .SEL_W(2), .N_ACTIVE(3), .TICK_DIV(4), .BLANK(1), .ACT_LOW(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_in(sel_in),
        .y(y), .idx(idx), .tick(tick)
    );

    scan_decoder #(
        .SEL_W(2), .N_ACTIVE(3), .TICK_DIV(4), .BLANK(1), .ACT_LOW(1)
    ) dut_low (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_in(sel_in),
        .y(y_l), .idx(idx_l), .tick(tick_l)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset();
        // First reset, asserted before any clock edge
        #2 rst_n = 1'b0;
        #1;
        cmp_cnt++;
        if (y !== 4'b0000 || idx !== 2'd0 || tick !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_init: y=%b idx=%0d tick=%b want y=0000 idx=0 tick=0", y, idx, tick);
        end
        cmp_cnt++;
        if (y_l !== 4'b1111) begin
            err_cnt++;
            $display("FAIL reset_init_low: y=%b want 1111", y_l);
        end
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1; mode = 1'b0; sel_in = 2'd2;
        @(negedge clk);
        cmp_cnt++;
        if (y !== 4'b0100 || idx !== 2'd2) begin
            err_cnt++;
            $display("FAIL reset_pre: y=%b idx=%0d want y=0100 idx=2", y, idx);
        end
        // Mid-cycle reset must act without a clock edge
        #2 rst_n = 1'b0;
        #1;
        cmp_cnt++;
        if (y !== 4'b0000 || idx !== 2'd0 || tick !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_async: y=%b idx=%0d tick=%b want y=0000 idx=0 tick=0", y, idx, tick);
        end
        cmp_cnt++;
        if (y_l !== 4'b1111 || idx_l !== 2'd0 || tick_l !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_async_low: y=%b idx=%0d tick=%b want y=1111 idx=0 tick=0", y_l, idx_l, tick_l);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_manual();
        logic [3:0] exp_hi [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [3:0] exp_lo [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        en = 1'b1; mode = 1'b0;
        for (int s = 0; s < 4; s++) begin
            sel_in = 2'(s);
            @(negedge clk);
            cmp_cnt++;
            if (y !== exp_hi[s] || idx !== 2'(s) || tick !== 1'b0) begin
                err_cnt++;
                $display("FAIL manual_sel%0d: y=%b idx=%0d tick=%b want y=%b idx=%0d tick=0", s, y, idx, tick, exp_hi[s], s);
            end
            cmp_cnt++;
            if (y_l !== exp_lo[s] || idx_l !== 2'(s)) begin
                err_cnt++;
                $display("FAIL manual_low_sel%0d: y=%b idx=%0d want y=%b idx=%0d", s, y_l, idx_l, exp_lo[s], s);
            end
        end
    endtask

    task automatic test_enable();
        en = 1'b1; mode = 1'b0; sel_in = 2'd2;
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        cmp_cnt++;
        if (y !== 4'b0000 || idx !== 2'd2 || tick !== 1'b0) begin
            err_cnt++;
            $display("FAIL enable_off: y=%b idx=%0d tick=%b want y=0000 idx=2 tick=0", y, idx, tick);
        end
        en = 1'b1;
        @(negedge clk);
        cmp_cnt++;
        if (y !== 4'b0100 || idx !== 2'd2) begin
            err_cnt++;
            $display("FAIL enable_on: y=%b idx=%0d want y=0100 idx=2", y, idx);
        end
    endtask

    task automatic test_scan();
        logic [1:0] e_idx;
        logic       e_tick;
        logic [3:0] e_y;
        en = 1'b1; mode = 1'b0; sel_in = 2'd0;
        @(negedge clk);
        mode = 1'b1;
        // Edge k after entering scan: tick on every 4th, idx 1,2,0; one dark cycle after each tick
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            e_tick = ((k % 4) == 0);
            e_idx  = 2'((k / 4) % 3);
            e_y    = e_tick ? 4'b0000 : (4'b0001 << e_idx);
            cmp_cnt++;
            if (y !== e_y || idx !== e_idx || tick !== e_tick) begin
                err_cnt++;
                $display("FAIL scan_edge%0d: y=%b idx=%0d tick=%b want y=%b idx=%0d tick=%b", k, y, idx, tick, e_y, e_idx, e_tick);
            end
        end
    endtask

    task automatic test_resume_out_of_range();
        en = 1'b1; mode = 1'b0; sel_in = 2'd3;
        @(negedge clk);
        mode = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            cmp_cnt++;
            if (y !== 4'b1000 || idx !== 2'd3 || tick !== 1'b0) begin
                err_cnt++;
                $display("FAIL resume_hold%0d: y=%b idx=%0d tick=%b want y=1000 idx=3 tick=0", k, y, idx, tick);
            end
        end
        @(negedge clk);
        cmp_cnt++;
        if (y !== 4'b0000 || idx !== 2'd0 || tick !== 1'b1) begin
            err_cnt++;
            $display("FAIL resume_wrap: y=%b idx=%0d tick=%b want y=0000 idx=0 tick=1", y, idx, tick);
        end
        @(negedge clk);
        cmp_cnt++;
        if (y !== 4'b0001 || idx !== 2'd0 || tick !== 1'b0) begin
            err_cnt++;
            $display("FAIL resume_show: y=%b idx=%0d tick=%b want y=0001 idx=0 tick=0", y, idx, tick);
        end
    endtask

    task automatic test_freeze_in_scan();
        // Prescaler is at 1 here; freezing must keep that phase
        en = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            cmp_cnt++;
            if (y !== 4'b0000 || idx !== 2'd0 || tick !== 1'b0) begin
                err_cnt++;
                $display("FAIL freeze%0d: y=%b idx=%0d tick=%b want y=0000 idx=0 tick=0", k, y, idx, tick);
            end
        end
        en = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            cmp_cnt++;
            if (y !== 4'b0001 || idx !== 2'd0 || tick !== 1'b0) begin
                err_cnt++;
                $display("FAIL unfreeze%0d: y=%b idx=%0d tick=%b want y=0001 idx=0 tick=0", k, y, idx, tick);
            end
        end
        @(negedge clk);
        cmp_cnt++;
        if (y !== 4'b0000 || idx !== 2'd1 || tick !== 1'b1) begin
            err_cnt++;
            $display("FAIL unfreeze_tick: y=%b idx=%0d tick=%b want y=0000 idx=1 tick=1", y, idx, tick);
        end
    endtask

    task automatic test_cancel_blank();
        // Blank counter is armed from the tick just seen; manual must override it
        mode = 1'b0; sel_in = 2'd3;
        @(negedge clk);
        cmp_cnt++;
        if (y !== 4'b1000 || idx !== 2'd3 || tick !== 1'b0) begin
            err_cnt++;
            $display("FAIL cancel_blank: y=%b idx=%0d tick=%b want y=1000 idx=3 tick=0", y, idx, tick);
        end
    endtask

    initial begin
        rst_n = 1'b1; en = 1'b0; mode = 1'b0; sel_in = 2'd0;
        test_reset();
        test_manual();
        test_enable();
        test_scan();
        test_resume_out_of_range();
        test_freeze_in_scan();
        test_cancel_blank();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
